// File: rtl/display_pkg.sv
// Shared constants, types and the lit-window threshold helper for the
// multiplexed 7-segment display scanner.
package display_pkg;

   localparam logic [6:0] SEG_OFF    = 7'h7F;
   localparam logic [3:0] AN_OFF     = 4'hF;
   localparam int         NUM_DIGITS = 4;
   localparam int         DIGIT_W    = 2;

   typedef enum logic [1:0] {
      PH_BLANK,
      PH_LIT,
      PH_DARK
   } phase_t;

   // First slot count past the lit window: blanking plus (bright+1) eighths of the rest.
   function automatic logic [31:0] lit_end(input logic [31:0] digit_cycles,
                                           input logic [31:0] blank_cycles,
                                           input logic [2:0]  bright);
      logic [31:0] unit;
      unit = (digit_cycles - blank_cycles) >> 3;
      return blank_cycles + unit * ({29'd0, bright} + 32'd1);
   endfunction

endpackage

// File: rtl/seg_scan_mux_scan_timer.sv
// Slot counter and digit index for the display scanner; flags the first
// cycle of each four-digit frame.
module scan_timer
   import display_pkg::*;
#(
   parameter int DIGIT_CYCLES = 50000,
   parameter int CW           = 16
) (
   input  logic               clk,
   input  logic               rst,
   output logic [DIGIT_W-1:0] digit,
   output logic [CW-1:0]      slot_cnt,
   output logic               frame_start
);

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_cnt <= '0;
         digit    <= '0;
      end else if (slot_cnt == CW'(DIGIT_CYCLES - 1)) begin
         slot_cnt <= '0;
         digit    <= digit + 2'd1;
      end else begin
         slot_cnt <= slot_cnt + 1'b1;
      end
   end

   assign frame_start = (slot_cnt == '0) && (digit == '0);

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment scanner: per-frame snapshot of four digit
// patterns, dead-time blanking and a brightness-scaled lit window per slot.
module seg_scan_mux
   import display_pkg::*;
#(
   parameter int DIGIT_CYCLES = 50000,
   parameter int BLANK_CYCLES = 400
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] seg0,
   input  logic [6:0] seg1,
   input  logic [6:0] seg2,
   input  logic [6:0] seg3,
   input  logic [2:0] bright,
   input  logic       blank_all,
   output logic [6:0] seg_out,
   output logic [3:0] an,
   output logic       frame_tick
);

   localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

   if (BLANK_CYCLES < 1 || DIGIT_CYCLES <= BLANK_CYCLES ||
       ((DIGIT_CYCLES - BLANK_CYCLES) % 8) != 0) begin : g_param_check
      $error("seg_scan_mux: bad DIGIT_CYCLES/BLANK_CYCLES combination");
   end

   logic [DIGIT_W-1:0] digit;
   logic [CW-1:0]      slot_cnt;
   logic               frame_start;
   logic [31:0]        slot_ext;
   logic [6:0]         shadow [NUM_DIGITS];
   phase_t             phase;

   scan_timer #(
      .DIGIT_CYCLES (DIGIT_CYCLES),
      .CW           (CW)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .digit       (digit),
      .slot_cnt    (slot_cnt),
      .frame_start (frame_start)
   );

   // Gating with rst keeps the pulse quiet while the counters are held at zero.
   assign frame_tick = frame_start & ~rst;
   assign slot_ext   = 32'(slot_cnt);

   // Loaded while digit 0 is still blanked, so the swap is never visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= SEG_OFF;
      end else if (frame_start) begin
         shadow[0] <= seg0;
         shadow[1] <= seg1;
         shadow[2] <= seg2;
         shadow[3] <= seg3;
      end
   end

   always_comb begin
      phase = PH_DARK;
      if (slot_ext < 32'(BLANK_CYCLES)) begin
         phase = PH_BLANK;
      end else if (slot_ext < lit_end(32'(DIGIT_CYCLES), 32'(BLANK_CYCLES), bright)) begin
         phase = PH_LIT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         an      <= AN_OFF;
         seg_out <= SEG_OFF;
      end else if (phase == PH_LIT && !blank_all) begin
         an      <= ~(4'b0001 << digit);
         seg_out <= shadow[digit];
      end else begin
         an      <= AN_OFF;
         seg_out <= SEG_OFF;
      end
   end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: hand-derived vector table, directed
// corner sequences and randomized inputs against a frame-arithmetic model.
module tb_seg_scan_mux;

   localparam int DC    = 18;
   localparam int BC    = 2;
   localparam int FRAME = 4 * DC;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] segIn [4];
   logic [2:0] bright = 3'd7;
   logic       blank_all = 1'b0;
   logic [6:0] seg_out;
   logic [3:0] an;
   logic       frame_tick;

   int checks = 0;
   int errors = 0;

   logic [6:0] mShadow [4];
   int         mCnt = 0;
   logic [3:0] expAn = 4'hF;
   logic [6:0] expSeg = 7'h7F;
   int         sinceRel = 0;
   int         base = 0;

   typedef struct {
      int         n;
      logic [3:0] an;
      logic [6:0] seg;
      logic       tick;
   } vec_t;

   vec_t vecs [13];

   seg_scan_mux #(
      .DIGIT_CYCLES (DC),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .seg0       (segIn[0]),
      .seg1       (segIn[1]),
      .seg2       (segIn[2]),
      .seg3       (segIn[3]),
      .bright     (bright),
      .blank_all  (blank_all),
      .seg_out    (seg_out),
      .an         (an),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   // Reference model: position in the frame is plain arithmetic on cycles since reset.
   task automatic modelEdge();
      int  pos, slot, dig;
      bit  lit;
      if (rst) begin
         mCnt   = 0;
         expAn  = 4'hF;
         expSeg = 7'h7F;
         for (int i = 0; i < 4; i++) mShadow[i] = 7'h7F;
      end else begin
         pos  = mCnt % FRAME;
         slot = pos % DC;
         dig  = pos / DC;
         lit  = (slot >= BC) && (slot < BC + ((DC - BC) / 8) * (int'(bright) + 1));
         expAn  = 4'hF;
         expSeg = 7'h7F;
         if (lit && !blank_all) begin
            expAn[dig] = 1'b0;
            expSeg     = mShadow[dig];
         end
         if (pos == 0) for (int i = 0; i < 4; i++) mShadow[i] = segIn[i];
         mCnt++;
      end
   endtask

   task automatic checkOutput(input string name, input logic [3:0] reqAn,
                              input logic [6:0] reqSeg, input logic reqTick);
      checks++;
      if (an !== reqAn || seg_out !== reqSeg || frame_tick !== reqTick) begin
         errors++;
         $display("[TB] FAIL %s @%0t: got an=%h seg_out=%h frame_tick=%b, required an=%h seg_out=%h frame_tick=%b",
                  name, $time, an, seg_out, frame_tick, reqAn, reqSeg, reqTick);
      end
   endtask

   task automatic checkCount(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, got, req);
      end
   endtask

   task automatic applyStimulus(input logic [6:0] s0, input logic [6:0] s1,
                                input logic [6:0] s2, input logic [6:0] s3,
                                input logic [2:0] b, input logic blk);
      segIn[0]  = s0;
      segIn[1]  = s1;
      segIn[2]  = s2;
      segIn[3]  = s3;
      bright    = b;
      blank_all = blk;
   endtask

   task automatic tick();
      @(posedge clk);
      modelEdge();
      #1;
      sinceRel++;
      checkOutput("model", expAn, expSeg, (!rst && (mCnt % FRAME == 0)));
   endtask

   task automatic releaseReset(input string name);
      rst = 1'b0;
      #1;
      sinceRel = 0;
      checkOutput(name, 4'hF, 7'h7F, 1'b1);
   endtask

   task automatic toFrameStart();
      while (mCnt % FRAME != 0) tick();
      base = sinceRel;
   endtask

   task automatic runTo(input int off);
      while (sinceRel < base + off) tick();
   endtask

   initial begin
      int litCount, offCount;

      vecs[0]  = '{0,  4'hF, 7'h7F, 1'b1};
      vecs[1]  = '{1,  4'hF, 7'h7F, 1'b0};
      vecs[2]  = '{2,  4'hF, 7'h7F, 1'b0};
      vecs[3]  = '{3,  4'hE, 7'h40, 1'b0};
      vecs[4]  = '{18, 4'hE, 7'h40, 1'b0};
      vecs[5]  = '{19, 4'hF, 7'h7F, 1'b0};
      vecs[6]  = '{20, 4'hF, 7'h7F, 1'b0};
      vecs[7]  = '{21, 4'hD, 7'h79, 1'b0};
      vecs[8]  = '{39, 4'hB, 7'h24, 1'b0};
      vecs[9]  = '{57, 4'h7, 7'h30, 1'b0};
      vecs[10] = '{72, 4'h7, 7'h30, 1'b1};
      vecs[11] = '{73, 4'hF, 7'h7F, 1'b0};
      vecs[12] = '{75, 4'hE, 7'h40, 1'b0};

      // Reset held for three edges, then full brightness from the vector table.
      applyStimulus(7'h40, 7'h79, 7'h24, 7'h30, 3'd7, 1'b0);
      for (int i = 0; i < 3; i++) tick();
      releaseReset("post_reset_tick");
      for (int i = 0; i < 13; i++) begin
         while (sinceRel < vecs[i].n) tick();
         checkOutput($sformatf("vec%0d", i), vecs[i].an, vecs[i].seg, vecs[i].tick);
      end

      // Minimum brightness: two lit cycles per slot.
      bright = 3'd0;
      toFrameStart();
      litCount = 0;
      for (int k = 1; k <= FRAME; k++) begin
         tick();
         if (k == 3 || k == 4) checkOutput("dim_lit", 4'hE, 7'h40, 1'b0);
         if (k == 5) checkOutput("dim_dark", 4'hF, 7'h7F, 1'b0);
         if (an !== 4'hF) litCount++;
      end
      checkCount("dim_lit_cycles", litCount, 8);

      // Tear-free snapshot: seg2 change mid-frame waits for the next frame.
      bright = 3'd7;
      toFrameStart();
      runTo(23);
      segIn[2] = 7'h12;
      runTo(39);
      checkOutput("tear_old", 4'hB, 7'h24, 1'b0);
      toFrameStart();
      runTo(39);
      checkOutput("tear_new", 4'hB, 7'h12, 1'b0);

      // blank_all pulse of five cycles inside slot 1.
      toFrameStart();
      runTo(20);
      offCount = 0;
      for (int k = 21; k <= 36; k++) begin
         tick();
         if (an === 4'hF) offCount++;
         if (k == 24) blank_all = 1'b1;
         if (k == 29) blank_all = 1'b0;
      end
      checkCount("blank_off_cycles", offCount, 5);
      runTo(72);
      checkOutput("blank_frame_period", 4'h7, 7'h30, 1'b1);

      // Reset during slot 2 lit window.
      base = sinceRel;
      runTo(40);
      rst = 1'b1;
      tick();
      checkOutput("midframe_reset", 4'hF, 7'h7F, 1'b0);
      releaseReset("midframe_restart_tick");
      base = 0;
      runTo(3);
      checkOutput("midframe_restart_d0", 4'hE, 7'h40, 1'b0);

      // Randomized patterns, brightness and blanking against the model.
      for (int f = 0; f < 8; f++) begin
         toFrameStart();
         for (int i = 0; i < 4; i++) segIn[i] = 7'($urandom);
         for (int k = 0; k < FRAME; k++) begin
            tick();
            bright    = 3'($urandom_range(0, 7));
            blank_all = ($urandom_range(0, 7) == 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
